temporal_encoder: RTL

//  Binary-to-race-logic transmitter. Accepts a vector of N binary spike times over a

---
 rtl/temporal_encoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/temporal_encoder.sv
// temporal_encoder: binary-to-race-logic transmitter.
// Latches N binary spike times via valid/ready and drives N active-low temporal
// lines over one gamma window of 2**W cycles, followed by one all-high BLANK cycle.
// Optional feature macro: TENC_FIRED_COUNT_EN (adds fired_cnt output).
module temporal_encoder #(
    parameter int N = 4,
    parameter int W = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*W-1:0]            in_data,
    output logic [N-1:0]              spike_n,
    output logic                      gamma_start,
`ifdef TENC_FIRED_COUNT_EN
    output logic [$clog2(N+1)-1:0]    fired_cnt,
`endif
    output logic                      busy
);

    localparam logic [W-1:0] INF    = '1;  // never-falls code
    localparam logic [W-1:0] T_LAST = '1;  // last window cycle, GAMMA-1
    localparam int           CW     = $clog2(N+1);

    typedef enum logic [1:0] {IDLE, RUN, BLANK} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     t_q, t_d;
    logic [N*W-1:0]   vals_q, vals_d;
    logic [N-1:0]     spike_n_q, spike_n_d;
    logic             gamma_start_q, gamma_start_d;
    logic             accept;

    // Line pattern for window cycle t: a line is low once t has reached its finite value.
    function automatic logic [N-1:0] lines(input logic [N*W-1:0] vals, input logic [W-1:0] t);
        logic [N-1:0] l;
        logic [W-1:0] v;
        l = '1;
        for (int i = 0; i < N; i++) begin
            v = vals[i*W +: W];
            if (v != INF && t >= v) l[i] = 1'b0;
        end
        return l;
    endfunction

    assign in_ready    = (state_q == IDLE) || (state_q == BLANK);
    assign busy        = (state_q != IDLE);
    assign accept      = in_valid & in_ready;
    assign spike_n     = spike_n_q;
    assign gamma_start = gamma_start_q;

    // Next-state, counter and registered-line computation; lines default high.
    always_comb begin
        state_d       = state_q;
        t_d           = t_q;
        vals_d        = vals_q;
        spike_n_d     = '1;
        gamma_start_d = 1'b0;
        case (state_q)
            IDLE:  state_d = IDLE;
            RUN: begin
                // Leaving for BLANK wins over the increment so t never wraps in RUN.
                if (t_q == T_LAST) begin
                    state_d = BLANK;
                end else begin
                    t_d       = t_q + 1'b1;
                    spike_n_d = lines(vals_q, t_q + 1'b1);
                end
            end
            BLANK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new window starts at t=0 using the incoming data directly, so v=0 is low at once.
        if (accept) begin
            state_d       = RUN;
            t_d           = '0;
            vals_d        = in_data;
            gamma_start_d = 1'b1;
            spike_n_d     = lines(in_data, '0);
        end
    end

    // State registers; async reset returns every line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            t_q           <= '0;
            vals_q        <= '1;
            spike_n_q     <= '1;
            gamma_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            vals_q        <= vals_d;
            spike_n_q     <= spike_n_d;
            gamma_start_q <= gamma_start_d;
        end
    end

`ifdef TENC_FIRED_COUNT_EN
    logic [CW-1:0] fired_cnt_q, fired_cnt_d;

    function automatic logic [CW-1:0] count_finite(input logic [N*W-1:0] vals);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            if (vals[i*W +: W] != INF) c = c + 1'b1;
        end
        return c;
    endfunction

    // Count of finite channels, captured on the edge that enters BLANK.
    always_comb begin
        fired_cnt_d = fired_cnt_q;
        if (state_q == RUN && t_q == T_LAST) fired_cnt_d = count_finite(vals_q);
    end

    // Fired-count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fired_cnt_q <= '0;
        else        fired_cnt_q <= fired_cnt_d;
    end

    assign fired_cnt = fired_cnt_q;
`endif

endmodule
